// File: rtl/ddr_cmd_arbiter.sv
// DDR4 command-bus arbiter: one command per cycle, fixed priority REF > CAS > PRE > ACT,
// enforcing tRRD, tFAW, tCCD and tRFC. Define DDR_ARB_AGE_EN to promote long-waiting ACTs.
module ddr_cmd_arbiter #(
    parameter int ADDR_W    = 21,
    parameter int T_RRD     = 4,
    parameter int T_FAW     = 20,
    parameter int T_CCD     = 4,
    parameter int T_RFC     = 160,
    parameter int AGE_LIMIT = 16
) (
    input  logic              clock_t,
    input  logic              reset,
    input  logic              act_req,
    input  logic [ADDR_W-1:0] act_addr,
    input  logic              cas_req,
    input  logic              cas_rw,
    input  logic [ADDR_W-1:0] cas_addr,
    input  logic              pre_req,
    input  logic [ADDR_W-1:0] pre_addr,
    input  logic              ref_req,
    output logic              act_gnt,
    output logic              cas_gnt,
    output logic              pre_gnt,
    output logic              ref_gnt,
    output logic              cmd_valid,
    output logic [2:0]        cmd_code,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              arb_busy
);
    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    localparam int RRD_W = (T_RRD > 1) ? $clog2(T_RRD) : 1;
    localparam int FAW_W = (T_FAW > 1) ? $clog2(T_FAW) : 1;
    localparam int CCD_W = (T_CCD > 1) ? $clog2(T_CCD) : 1;
    localparam int RFC_W = (T_RFC > 1) ? $clog2(T_RFC) : 1;

    typedef enum logic { ARB_RUN = 1'b0, ARB_REFRESH = 1'b1 } arb_state_t;
    typedef enum logic [2:0] { SEL_NONE, SEL_ACT, SEL_CAS, SEL_PRE, SEL_REF } sel_t;

    arb_state_t        state_q, state_d;
    sel_t              sel;
    logic [RRD_W-1:0]  rrd_cnt_q, rrd_cnt_d;
    logic [CCD_W-1:0]  ccd_cnt_q, ccd_cnt_d;
    logic [RFC_W-1:0]  rfc_cnt_q, rfc_cnt_d;
    logic [FAW_W-1:0]  faw_cnt_q [4];
    logic [FAW_W-1:0]  faw_cnt_d [4];
    logic              faw_loaded;
    logic              act_gnt_q, act_gnt_d, cas_gnt_q, cas_gnt_d;
    logic              pre_gnt_q, pre_gnt_d, ref_gnt_q, ref_gnt_d;
    logic              cmd_valid_q, cmd_valid_d, arb_busy_q, arb_busy_d;
    logic [2:0]        cmd_code_q, cmd_code_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic              faw_full, act_elig, cas_elig, pre_elig, ref_elig, act_promote;

    // A source's request is ignored while its own grant is on the bus.
    assign faw_full = (faw_cnt_q[0] != '0) && (faw_cnt_q[1] != '0) &&
                      (faw_cnt_q[2] != '0) && (faw_cnt_q[3] != '0);
    assign act_elig = act_req && !act_gnt_q && (rrd_cnt_q == '0) && !faw_full;
    assign cas_elig = cas_req && !cas_gnt_q && (ccd_cnt_q == '0);
    assign pre_elig = pre_req && !pre_gnt_q;
    assign ref_elig = ref_req && !ref_gnt_q;

`ifdef DDR_ARB_AGE_EN
    logic [4:0] act_age_q, act_age_d;

    always_comb begin
        act_age_d = act_age_q;
        if (sel == SEL_ACT) begin
            act_age_d = 5'd0;
        end else if (state_q == ARB_RUN && act_elig && act_age_q != 5'd31) begin
            act_age_d = act_age_q + 5'd1;
        end
    end

    always_ff @(posedge clock_t) begin
        if (reset) act_age_q <= 5'd0;
        else       act_age_q <= act_age_d;
    end

    assign act_promote = (32'(act_age_q) >= AGE_LIMIT);
`else
    assign act_promote = 1'b0 && (AGE_LIMIT > 0);
`endif

    always_comb begin
        sel = SEL_NONE;
        if (state_q == ARB_RUN) begin
            if (ref_elig)                     sel = SEL_REF;
            else if (act_promote && act_elig) sel = SEL_ACT;
            else if (cas_elig)                sel = SEL_CAS;
            else if (pre_elig)                sel = SEL_PRE;
            else if (act_elig)                sel = SEL_ACT;
        end
    end

    // Counters load T-1 on their grant and count down to zero; zero means eligible.
    always_comb begin
        rrd_cnt_d  = (rrd_cnt_q != '0) ? rrd_cnt_q - 1'b1 : '0;
        ccd_cnt_d  = (ccd_cnt_q != '0) ? ccd_cnt_q - 1'b1 : '0;
        rfc_cnt_d  = (rfc_cnt_q != '0) ? rfc_cnt_q - 1'b1 : '0;
        faw_loaded = 1'b0;
        if (sel == SEL_ACT) rrd_cnt_d = RRD_W'(T_RRD - 1);
        if (sel == SEL_CAS) ccd_cnt_d = CCD_W'(T_CCD - 1);
        if (sel == SEL_REF) rfc_cnt_d = RFC_W'(T_RFC - 1);
        for (int i = 0; i < 4; i++) begin
            if (sel == SEL_ACT && !faw_loaded && faw_cnt_q[i] == '0) begin
                faw_cnt_d[i] = FAW_W'(T_FAW - 1);
                faw_loaded   = 1'b1;
            end else begin
                faw_cnt_d[i] = (faw_cnt_q[i] != '0) ? faw_cnt_q[i] - 1'b1 : '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_RUN:     if (sel == SEL_REF) state_d = ARB_REFRESH;
            ARB_REFRESH: if (rfc_cnt_q <= RFC_W'(1)) state_d = ARB_RUN;
            default:     state_d = ARB_RUN;
        endcase
    end

    always_comb begin
        act_gnt_d   = 1'b0;
        cas_gnt_d   = 1'b0;
        pre_gnt_d   = 1'b0;
        ref_gnt_d   = 1'b0;
        cmd_valid_d = (sel != SEL_NONE);
        cmd_code_d  = CMD_NOP;
        cmd_addr_d  = '0;
        arb_busy_d  = (state_q == ARB_REFRESH);
        case (sel)
            SEL_ACT: begin act_gnt_d = 1'b1; cmd_code_d = CMD_ACT; cmd_addr_d = act_addr; end
            SEL_CAS: begin
                cas_gnt_d  = 1'b1;
                cmd_code_d = cas_rw ? CMD_RD : CMD_WR;
                cmd_addr_d = cas_addr;
            end
            SEL_PRE: begin pre_gnt_d = 1'b1; cmd_code_d = CMD_PRE; cmd_addr_d = pre_addr; end
            SEL_REF: begin ref_gnt_d = 1'b1; cmd_code_d = CMD_REF; end
            default: ;
        endcase
    end

    always_ff @(posedge clock_t) begin
        if (reset) begin
            state_q     <= ARB_RUN;
            rrd_cnt_q   <= '0;
            ccd_cnt_q   <= '0;
            rfc_cnt_q   <= '0;
            for (int i = 0; i < 4; i++) faw_cnt_q[i] <= '0;
            act_gnt_q   <= 1'b0;
            cas_gnt_q   <= 1'b0;
            pre_gnt_q   <= 1'b0;
            ref_gnt_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= CMD_NOP;
            cmd_addr_q  <= '0;
            arb_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rrd_cnt_q   <= rrd_cnt_d;
            ccd_cnt_q   <= ccd_cnt_d;
            rfc_cnt_q   <= rfc_cnt_d;
            for (int i = 0; i < 4; i++) faw_cnt_q[i] <= faw_cnt_d[i];
            act_gnt_q   <= act_gnt_d;
            cas_gnt_q   <= cas_gnt_d;
            pre_gnt_q   <= pre_gnt_d;
            ref_gnt_q   <= ref_gnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_addr_q  <= cmd_addr_d;
            arb_busy_q  <= arb_busy_d;
        end
    end

    assign act_gnt   = act_gnt_q;
    assign cas_gnt   = cas_gnt_q;
    assign pre_gnt   = pre_gnt_q;
    assign ref_gnt   = ref_gnt_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_addr  = cmd_addr_q;
    assign arb_busy  = arb_busy_q;

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Bench for ddr_cmd_arbiter: a timestamp-based model of the command bus checked every cycle,
// plus directed grant-cycle expectations. A second instance with T_RRD = 2 exercises tFAW.
module tb_ddr_cmd_arbiter;
    localparam int AW        = 21;
    localparam int T_RRD     = 4;
    localparam int T_FAW     = 20;
    localparam int T_CCD     = 4;
    localparam int T_RFC     = 160;
    localparam int AGE_LIMIT = 16;

    logic clock_t = 1'b0;
    always #5 clock_t = ~clock_t;

    logic          reset;
    logic          act_req, cas_req, cas_rw, pre_req, ref_req, act2_req;
    logic [AW-1:0] act_addr, cas_addr, pre_addr, act2_addr;
    logic          act_gnt, cas_gnt, pre_gnt, ref_gnt, cmd_valid, arb_busy;
    logic [2:0]    cmd_code;
    logic [AW-1:0] cmd_addr;
    logic          f_act_gnt, f_cas_gnt, f_pre_gnt, f_ref_gnt, f_cmd_valid, f_arb_busy;
    logic [2:0]    f_cmd_code;
    logic [AW-1:0] f_cmd_addr;

    ddr_cmd_arbiter #(.ADDR_W(AW), .T_RRD(T_RRD), .T_FAW(T_FAW), .T_CCD(T_CCD),
                      .T_RFC(T_RFC), .AGE_LIMIT(AGE_LIMIT)) dut (
        .clock_t(clock_t), .reset(reset),
        .act_req(act_req), .act_addr(act_addr),
        .cas_req(cas_req), .cas_rw(cas_rw), .cas_addr(cas_addr),
        .pre_req(pre_req), .pre_addr(pre_addr), .ref_req(ref_req),
        .act_gnt(act_gnt), .cas_gnt(cas_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_addr(cmd_addr), .arb_busy(arb_busy)
    );

    ddr_cmd_arbiter #(.ADDR_W(AW), .T_RRD(2), .T_FAW(T_FAW), .T_CCD(T_CCD),
                      .T_RFC(T_RFC), .AGE_LIMIT(AGE_LIMIT)) dut_faw (
        .clock_t(clock_t), .reset(reset),
        .act_req(act2_req), .act_addr(act2_addr),
        .cas_req(1'b0), .cas_rw(1'b0), .cas_addr('0),
        .pre_req(1'b0), .pre_addr('0), .ref_req(1'b0),
        .act_gnt(f_act_gnt), .cas_gnt(f_cas_gnt), .pre_gnt(f_pre_gnt), .ref_gnt(f_ref_gnt),
        .cmd_valid(f_cmd_valid), .cmd_code(f_cmd_code), .cmd_addr(f_cmd_addr),
        .arb_busy(f_arb_busy)
    );

    int errors = 0;
    int checks = 0;

    // Model state: absolute cycle of the last grant per source, recent ACT timestamps.
    int t = 0;
    int last_act = -1000, last_cas = -1000, last_pre = -1000, last_ref = -1000;
    int act_hist[$];
    int age = 0;
    logic [28:0] exp_vec, dut_vec;

    // Requesters: each holds its req high until it has received *_left grants.
    int act_left = 0, cas_left = 0, pre_left = 0, ref_left = 0, act2_left = 0;
    int pc;
    int act_cyc[$], cas_cyc[$], pre_cyc[$], ref_cyc[$], f_act_cyc[$], code_log[$], busy_log[$];

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic model_step();
        bit locked, a_ok, c_ok, p_ok, r_ok, promo;
        int win;
        exp_vec = '0;
        if (reset) begin
            last_act = -1000; last_cas = -1000; last_pre = -1000; last_ref = -1000;
            act_hist.delete();
            age = 0;
            return;
        end
        locked = (t - last_ref) < T_RFC;
        a_ok   = act_req && (last_act != t - 1) && (t - last_act >= T_RRD) &&
                 (act_hist.size() < 4 || t - act_hist[act_hist.size() - 4] >= T_FAW);
        c_ok   = cas_req && (last_cas != t - 1) && (t - last_cas >= T_CCD);
        p_ok   = pre_req && (last_pre != t - 1);
        r_ok   = ref_req && (last_ref != t - 1);
        promo  = 1'b0;
`ifdef DDR_ARB_AGE_EN
        promo = (age >= AGE_LIMIT);
`endif
        win = 0;
        if (!locked) begin
            if (r_ok)               win = 4;
            else if (promo && a_ok) win = 1;
            else if (c_ok)          win = 2;
            else if (p_ok)          win = 3;
            else if (a_ok)          win = 1;
        end
`ifdef DDR_ARB_AGE_EN
        if (win == 1) age = 0;
        else if (!locked && a_ok && age < 31) age++;
`endif
        case (win)
            1: begin
                last_act = t;
                act_hist.push_back(t);
                if (act_hist.size() > 4) void'(act_hist.pop_front());
                exp_vec = {4'b1000, 1'b1, 3'd1, act_addr, 1'b0};
            end
            2: begin
                last_cas = t;
                exp_vec  = {4'b0100, 1'b1, cas_rw ? 3'd2 : 3'd3, cas_addr, 1'b0};
            end
            3: begin
                last_pre = t;
                exp_vec  = {4'b0010, 1'b1, 3'd4, pre_addr, 1'b0};
            end
            4: begin
                last_ref = t;
                exp_vec  = {4'b0001, 1'b1, 3'd5, {AW{1'b0}}, 1'b0};
            end
            default: exp_vec[0] = locked;
        endcase
    endtask

    task automatic set_reqs();
        act_req  = (act_left > 0);
        cas_req  = (cas_left > 0);
        pre_req  = (pre_left > 0);
        ref_req  = (ref_left > 0);
        act2_req = (act2_left > 0);
    endtask

    // One clock: DUT samples at posedge, model and compare at negedge, then requesters react.
    task automatic tick();
        @(posedge clock_t);
        @(negedge clock_t);
        t++;
        pc++;
        model_step();
        dut_vec = {act_gnt, cas_gnt, pre_gnt, ref_gnt, cmd_valid, cmd_code, cmd_addr, arb_busy};
        checks++;
        if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL cmd_bus t=%0d: got %h expected %h", t, dut_vec, exp_vec);
        end
        if (act_gnt) act_cyc.push_back(pc);
        if (cas_gnt) cas_cyc.push_back(pc);
        if (pre_gnt) pre_cyc.push_back(pc);
        if (ref_gnt) ref_cyc.push_back(pc);
        if (f_act_gnt) f_act_cyc.push_back(pc);
        code_log.push_back(int'(cmd_code));
        busy_log.push_back(int'(arb_busy));
        if (act_gnt && act_left > 0) act_left--;
        if (cas_gnt && cas_left > 0) cas_left--;
        if (pre_gnt && pre_left > 0) pre_left--;
        if (ref_gnt && ref_left > 0) ref_left--;
        if (f_act_gnt && act2_left > 0) act2_left--;
        set_reqs();
    endtask

    task automatic start_phase();
        pc = 0;
        act_cyc.delete(); cas_cyc.delete(); pre_cyc.delete(); ref_cyc.delete();
        f_act_cyc.delete(); code_log.delete(); busy_log.delete();
        set_reqs();
    endtask

    task automatic run_phase(input string name);
        int n = 0;
        while ((act_left + cas_left + pre_left + ref_left + act2_left) > 0 && n < 400) begin
            tick();
            n++;
        end
        if ((act_left + cas_left + pre_left + ref_left + act2_left) > 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got pending requests after %0d cycles, required none", name, n);
            act_left = 0; cas_left = 0; pre_left = 0; ref_left = 0; act2_left = 0;
            set_reqs();
        end
        repeat (25) tick();
    endtask

    initial begin
        reset     = 1'b1;
        cas_rw    = 1'b1;
        act_addr  = 21'h1A5A5;
        cas_addr  = 21'h0C3C3;
        pre_addr  = 21'h15000;
        act2_addr = 21'h0F0F0;
        act_left = 1; cas_left = 1; pre_left = 1; ref_left = 1;
        start_phase();

        // Reset held with every request high: nothing may issue.
        repeat (3) tick();
        check_int("reset_code", int'(cmd_code), 0);
        check_int("reset_busy", int'(arb_busy), 0);
        reset = 1'b0;
        start_phase();
        run_phase("reset_release");
        check_int("ref_after_reset", qget(ref_cyc, 0), 1);
        check_int("cas_after_rfc", qget(cas_cyc, 0), 161);
        check_int("pre_after_cas", qget(pre_cyc, 0), 162);
        check_int("act_after_pre", qget(act_cyc, 0), 163);

        // tRRD: ACT kept requested, three grants.
        act_addr = AW'($urandom_range(0, 21'h1FFFFF));
        act_left = 3;
        start_phase();
        run_phase("trrd");
        check_int("trrd_g0", qget(act_cyc, 0), 1);
        check_int("trrd_g1", qget(act_cyc, 1), 5);
        check_int("trrd_g2", qget(act_cyc, 2), 9);

        // tCCD with writes.
        cas_rw   = 1'b0;
        cas_addr = AW'($urandom_range(0, 21'h1FFFFF));
        cas_left = 3;
        start_phase();
        run_phase("tccd");
        check_int("tccd_g0", qget(cas_cyc, 0), 1);
        check_int("tccd_g1", qget(cas_cyc, 1), 5);
        check_int("tccd_g2", qget(cas_cyc, 2), 9);
        check_int("wr_code", qget(code_log, 0), 3);

        // Priority: CAS, PRE, ACT together with a read.
        cas_rw   = 1'b1;
        cas_left = 1; pre_left = 1; act_left = 1;
        start_phase();
        run_phase("priority");
        check_int("prio_c1", qget(code_log, 0), 2);
        check_int("prio_c2", qget(code_log, 1), 4);
        check_int("prio_c3", qget(code_log, 2), 1);

        // CAS and ACT both eligible: CAS then ACT.
        cas_left = 1; act_left = 1;
        start_phase();
        run_phase("cas_act");
        check_int("cas_act_cas", qget(cas_cyc, 0), 1);
        check_int("cas_act_act", qget(act_cyc, 0), 2);

        // Refresh lockout with a CAS pending.
        ref_left = 1; cas_left = 1;
        start_phase();
        run_phase("refresh");
        check_int("rfc_ref", qget(ref_cyc, 0), 1);
        check_int("rfc_busy_c1", qget(busy_log, 0), 0);
        check_int("rfc_busy_c2", qget(busy_log, 1), 1);
        check_int("rfc_busy_c160", qget(busy_log, 159), 1);
        check_int("rfc_busy_c161", qget(busy_log, 160), 0);
        check_int("rfc_cas", qget(cas_cyc, 0), 161);

        // Reset in the middle of a refresh lockout aborts it.
        ref_left = 1; cas_left = 1;
        start_phase();
        repeat (10) tick();
        check_int("midrfc_ref", qget(ref_cyc, 0), 1);
        check_int("midrfc_busy", int'(arb_busy), 1);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        start_phase();
        run_phase("midrfc");
        check_int("midrfc_cas", qget(cas_cyc, 0), 1);

        // tFAW on the T_RRD = 2 instance: four at RRD spacing, fifth waits for the window.
        act2_left = 5;
        start_phase();
        run_phase("tfaw");
        check_int("tfaw_g0", qget(f_act_cyc, 0), 1);
        check_int("tfaw_g1", qget(f_act_cyc, 1), 3);
        check_int("tfaw_g2", qget(f_act_cyc, 2), 5);
        check_int("tfaw_g3", qget(f_act_cyc, 3), 7);
        check_int("tfaw_g4", qget(f_act_cyc, 4), 21);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion by 2 ms, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
